dac_spi_tx: RTL

Serial transmitter that drives a 12-bit SPI DAC. It is the output-side counterpart of the ADC serial receiver. It accepts a two's-complement sample on a one-cycle `start` strobe and converts it to offset binary. It frames the sample into a 16-bit word and shifts it out MSB-first on `SDATA`, generating `CS` and `SCLK` from the system clock. It sits between the filter datapath and the DAC pins.

---
 rtl/dac_spi_tx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/dac_spi_tx.sv
// rtl/dac_spi_tx.sv - 12-bit SPI DAC serial transmitter; DAC_POWERDOWN_EN adds the pd[1:0] frame field.
module dac_spi_tx #(
    parameter int DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] data_in,
`ifdef DAC_POWERDOWN_EN
    input  logic [1:0]  pd,
`endif
    output logic        CS,
    output logic        SCLK,
    output logic        SDATA,
    output logic        busy,
    output logic        tx_done_tick
);
    localparam int            DW     = $clog2(DIV + 1);
    localparam logic [DW-1:0] DIV_TC = DW'(DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_QUIET} state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [4:0]    bit_q, bit_d;
    logic [15:0]   sh_q, sh_d;
    logic          cs_q, cs_d;
    logic          sclk_q, sclk_d;
    logic          busy_q;
    logic          tick_q, tick_d;
    logic [1:0]    pd_w;
    logic [15:0]   frame_w;
    logic          tc_w;

`ifdef DAC_POWERDOWN_EN
    assign pd_w = pd;
`else
    assign pd_w = 2'b00;
`endif

    // Bit 11 inverted: two's complement to offset binary.
    assign frame_w = {2'b00, pd_w, ~data_in[11], data_in[10:0]};
    assign tc_w    = (div_q == DIV_TC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b1;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            busy_q  <= (state_d != S_IDLE);
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (tc_w && !sclk_q && (bit_q == 5'd16)) state_d = S_QUIET;
            S_QUIET: if (tc_w) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The shift register is zero outside a frame, so its MSB doubles as SDATA.
    always_comb begin
        div_d  = div_q;
        bit_d  = bit_q;
        sh_d   = sh_q;
        cs_d   = cs_q;
        sclk_d = sclk_q;
        tick_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cs_d   = 1'b1;
                sclk_d = 1'b1;
                if (start) begin
                    sh_d  = frame_w;
                    cs_d  = 1'b0;
                    div_d = '0;
                    bit_d = '0;
                end
            end
            S_SHIFT: begin
                if (!tc_w) begin
                    div_d = div_q + DW'(1);
                end else begin
                    div_d = '0;
                    if (sclk_q) begin
                        sclk_d = 1'b0;
                        bit_d  = bit_q + 5'd1;
                    end else if (bit_q == 5'd16) begin
                        sclk_d = 1'b1;
                        cs_d   = 1'b1;
                        sh_d   = '0;
                    end else begin
                        sclk_d = 1'b1;
                        sh_d   = {sh_q[14:0], 1'b0};
                    end
                end
            end
            S_QUIET: begin
                if (tc_w) begin
                    div_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            default: begin
                cs_d   = 1'b1;
                sclk_d = 1'b1;
                sh_d   = '0;
            end
        endcase
    end

    assign CS           = cs_q;
    assign SCLK         = sclk_q;
    assign SDATA        = sh_q[15];
    assign busy         = busy_q;
    assign tx_done_tick = tick_q;

endmodule
